tiny_uart_loader: RTL and testbench
===================================

// Module: tiny_uart_loader
// PURPOSE
// - Serial firmware loader upstream of TinyRAM: receives a framed image over UART RX and writes it
//   byte-by-byte into RAM through TinyRAM's write/select/addr/wdata port.
// - Holds the core in reset (cpu_hold) until a frame loads with a valid checksum, then releases it.
// - Sits between the board RX pin and the RAM write port, muxed ahead of the core's store path.
// PARAMETERS
// - CLKS_PER_BIT  434   clk cycles per UART bit (50 MHz / 115200); must be >= 4
// - SYNC_BYTE     8'hA5 frame start marker
// PORTS
// - clk        in   1  system clock, all logic on posedge
// - rst        in   1  reset, asynchronous, active-high
// - rx         in   1  UART RX line, idle high, 8N1, LSB first; asynchronous to clk
// - ram_addr   out  8  RAM byte address
// - ram_wdata  out  8  RAM write data
// - ram_write  out  1  RAM write strobe, one-cycle pulse per data byte
// - ram_select out  1  RAM select, asserted together with ram_write only
// - cpu_hold   out  1  1 = keep core in reset
// - busy       out  1  frame in progress (states LEN, DATA, CSUM)
// - load_ok    out  1  last frame completed with good checksum (level)
// - load_err   out  1  last frame failed: checksum or framing error (level)
// BEHAVIOUR
// - Reset values: ram_addr=0, ram_wdata=0, ram_write=0, ram_select=0, cpu_hold=1, busy=0,
//   load_ok=0, load_err=0, state=IDLE, count=0, sum=0. Reset mid-frame aborts the frame; RAM
//   contents written so far are left as written.
// - rx passes a 2-flop synchronizer before use; synchronizer flops reset to 1.
// - UART byte receiver: falling edge starts a frame; start bit re-checked at CLKS_PER_BIT/2
//   (high there = glitch, return to idle); each data bit and the stop bit are sampled at bit
//   centres. A stop bit of 0 is a framing error. rx_valid pulses 1 cycle with rx_byte.
// - Frame format: SYNC_BYTE, LEN (0 encodes 256), LEN data bytes, CSUM. CSUM is the 8-bit
//   wrap-around sum of the data bytes.
// - FSM, advancing only on rx_valid:
//   - IDLE: SYNC_BYTE -> LEN; clear load_ok/load_err; any other byte is ignored.
//   - LEN: store count = byte (9-bit; 0 -> 256); sum=0; addr=0 -> DATA.
//   - DATA: register ram_wdata=byte, ram_addr=addr; pulse ram_write=ram_select=1 for exactly
//     1 cycle; sum += byte (mod 256); addr += 1 (wraps 255->0 after the 256th byte);
//     count -= 1; count reaching 0 -> CSUM.
//   - CSUM: byte == sum -> DONE (load_ok=1, cpu_hold=0); else -> ERR (load_err=1).
//   - DONE: cpu_hold=0. SYNC_BYTE -> LEN with cpu_hold=1 and load_ok cleared (reload).
//   - ERR: cpu_hold=1. SYNC_BYTE -> LEN (retry); other bytes ignored.
// - Framing error in any state except IDLE/DONE -> ERR (load_err=1); the byte is discarded.
//   In IDLE/DONE the byte is dropped silently.
// - Latency: write strobe on the cycle after rx_valid; RAM captures on the following posedge.
// - cpu_hold is low only in DONE; it is a registered output with no glitches.
// - ram_write and ram_select are never high outside DATA-byte pulses (the core's store path owns
//   RAM otherwise).
// STRUCTURE
// - Shared package tiny_pkg: loader state enum (IDLE, LEN, DATA, CSUM, DONE, ERR),
//   SYNC_BYTE default, and the 8-bit address/data width constants shared with the RAM.
// - One sub-module, tiny_uart_rx (CLKS_PER_BIT): includes the synchronizer and the byte
//   receiver; outputs rx_byte[7:0], rx_valid, rx_frame_err.
// - The top holds the frame FSM, count/addr/sum registers, and registered RAM-port outputs.
// TESTING (bench CLKS_PER_BIT=8, with TinyRAM attached)
// - Reset, rx idle high -> cpu_hold=1, busy=0, ram_write=0; hold for 1000 cycles.
// - Send A5 03 11 22 33 66 -> RAM[0..2]=11,22,33; exactly 3 write pulses; load_ok=1, cpu_hold=0.
// - Send A5 02 01 02 FF -> load_err=1, cpu_hold=1, RAM[0..1]=01,02; then resend with CSUM 03
//   -> load_ok=1.
// - Send A5 00, then 256 bytes i (0..255), then CSUM 80 -> RAM[i]=i; addr wraps to 0; load_ok=1.
// - Send stop bit=0 on the 2nd data byte of A5 04 ... -> load_err=1; the bad byte is not written.
// - Send stray bytes 00 FF 5A before A5 01 7E 7E -> they are ignored; RAM[0]=7E, load_ok=1.
//   Then assert rst mid-frame -> all outputs return to reset values on the same edge.

Source files
------------

// File: rtl/tiny_pkg.sv
// Types and constants shared by the UART loader and the TinyRAM write port.
package tiny_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/tiny_uart_rx.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer; bit timing
// comes from a down-counter that fires at each bit centre.
module tiny_uart_rx
    import tiny_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_byte,
    output logic              rx_valid,
    output logic              rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t         state, state_d;
    logic              rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [2:0]        bit_idx, bit_idx_d;
    logic [DATA_W-1:0] shreg, shreg_d, byte_d;
    logic              valid_d, ferr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            bit_idx      <= bit_idx_d;
            shreg        <= shreg_d;
            rx_byte      <= byte_d;
            rx_valid     <= valid_d;
            rx_frame_err <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        byte_d    = rx_byte;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state)
            RX_IDLE: begin
                // Edge-qualified so a line held low after a bad stop bit cannot retrigger
                if (rx_prev && !rx_sync) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (rx_sync) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d   = RX_DATA;
                        cnt_d     = FULL_LOAD;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shreg_d = {rx_sync, shreg[DATA_W-1:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_idx == 3'd7) state_d = RX_STOP;
                    else bit_idx_d = bit_idx + 3'd1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    state_d = RX_IDLE;
                    if (rx_sync) begin
                        valid_d = 1'b1;
                        byte_d  = shreg;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/tiny_uart_loader.sv
// Serial firmware loader: receives SYNC/LEN/data/CSUM frames over UART,
// writes the data into TinyRAM and holds the core in reset until a good load.
//
// state | meaning
// IDLE  | waiting for SYNC after reset, core held
// LEN   | SYNC seen, next byte is the data length (0 = 256)
// DATA  | each byte is written to RAM and summed
// CSUM  | next byte is compared against the running sum
// DONE  | image good, core released; SYNC starts a reload
// ERR   | checksum or framing error, core held; SYNC retries
module tiny_uart_loader
    import tiny_pkg::*;
#(
    parameter int                CLKS_PER_BIT = 434,
    parameter logic [DATA_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_write,
    output logic              ram_select,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_ok,
    output logic              load_err
);

    logic [DATA_W-1:0] rx_byte;
    logic              rx_valid, rx_frame_err;

    tiny_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    loader_state_t     state, state_d;
    logic [8:0]        count, count_d;
    logic [ADDR_W-1:0] addr, addr_d, waddr_d;
    logic [DATA_W-1:0] sum, sum_d, wdata_d;
    logic              write_d, ok_d, err_d, hold_d, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            addr       <= '0;
            sum        <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_write  <= 1'b0;
            ram_select <= 1'b0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_d;
            count      <= count_d;
            addr       <= addr_d;
            sum        <= sum_d;
            ram_addr   <= waddr_d;
            ram_wdata  <= wdata_d;
            ram_write  <= write_d;
            ram_select <= write_d;
            cpu_hold   <= hold_d;
            busy       <= busy_d;
            load_ok    <= ok_d;
            load_err   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        count_d = count;
        addr_d  = addr;
        sum_d   = sum;
        waddr_d = ram_addr;
        wdata_d = ram_wdata;
        write_d = 1'b0;
        ok_d    = load_ok;
        err_d   = load_err;
        if (rx_frame_err) begin
            if (state != IDLE && state != DONE) begin
                state_d = ERR;
                err_d   = 1'b1;
            end
        end else if (rx_valid) begin
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = LEN;
                        ok_d    = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                LEN: begin
                    count_d = (rx_byte == '0) ? 9'd256 : {1'b0, rx_byte};
                    sum_d   = '0;
                    addr_d  = '0;
                    state_d = DATA;
                end
                DATA: begin
                    waddr_d = addr;
                    wdata_d = rx_byte;
                    write_d = 1'b1;
                    sum_d   = sum + rx_byte;
                    addr_d  = addr + 1'b1;
                    count_d = count - 9'd1;
                    if (count == 9'd1) state_d = CSUM;
                end
                CSUM: begin
                    if (rx_byte == sum) begin
                        state_d = DONE;
                        ok_d    = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Derived from next state so the registered outputs track state exactly
        hold_d = (state_d != DONE);
        busy_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
    end

endmodule

// File: tb/tb_tiny_uart_loader.sv
// Directed bench for tiny_uart_loader with a TinyRAM model and a write scoreboard.
module tb_tiny_uart_loader;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] ram_addr, ram_wdata;
    logic       ram_write, ram_select, cpu_hold, busy, load_ok, load_err;

    tiny_uart_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_write  (ram_write),
        .ram_select (ram_select),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .load_ok    (load_ok),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_write && ram_select) mem[ram_addr] <= ram_wdata;
    end

    int          checks = 0;
    int          passed = 0;
    int          write_pulses = 0;
    logic        prev_write = 1'b0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ram_write || ram_select) begin
            write_pulses++;
            chk("write_select_pair", {ram_write, ram_select}, 2'b11);
            chk("write_one_cycle", prev_write, 1'b0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {ram_addr, ram_wdata}, 16'hxxxx);
            end else begin
                exp_w = exp_q.pop_front();
                chk("write_addr_data", {ram_addr, ram_wdata}, exp_w);
            end
        end
        prev_write = ram_write;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (stop_bit ? 3 : 2 * CPB) tick();
    endtask

    task automatic send_data(input logic [7:0] a, input logic [7:0] b);
        exp_q.push_back({a, b});
        send_byte(b, 1'b1);
    endtask

    task automatic chk_status(input string tag, input logic ok, input logic err, input logic hold);
        chk({tag, "_load_ok"}, load_ok, ok);
        chk({tag, "_load_err"}, load_err, err);
        chk({tag, "_cpu_hold"}, cpu_hold, hold);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        // Reset and idle
        repeat (3) tick();
        chk("rst_cpu_hold", cpu_hold, 1'b1);
        chk("rst_ram_write", ram_write, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (i % 250 == 0) begin
                chk("idle_cpu_hold", cpu_hold, 1'b1);
                chk("idle_busy", busy, 1'b0);
                chk("idle_ram_addr", ram_addr, 8'h00);
                chk("idle_ram_wdata", ram_wdata, 8'h00);
            end
        end
        chk_status("idle", 1'b0, 1'b0, 1'b1);

        // Good 3-byte frame
        write_pulses = 0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        chk("frame1_busy", busy, 1'b1);
        send_data(8'd0, 8'h11);
        send_data(8'd1, 8'h22);
        send_data(8'd2, 8'h33);
        chk("frame1_busy_csum", busy, 1'b1);
        send_byte(8'h66, 1'b1);
        chk("frame1_pulses", write_pulses, 3);
        chk("frame1_ram0", mem[0], 8'h11);
        chk("frame1_ram1", mem[1], 8'h22);
        chk("frame1_ram2", mem[2], 8'h33);
        chk_status("frame1", 1'b1, 1'b0, 1'b0);

        // Bad checksum, then retry with the correct one
        send_byte(8'hA5, 1'b1);
        chk("frame2_reload_hold", cpu_hold, 1'b1);
        chk("frame2_reload_ok_clr", load_ok, 1'b0);
        send_byte(8'h02, 1'b1);
        send_data(8'd0, 8'h01);
        send_data(8'd1, 8'h02);
        send_byte(8'hFF, 1'b1);
        chk_status("frame2_bad", 1'b0, 1'b1, 1'b1);
        chk("frame2_ram0", mem[0], 8'h01);
        chk("frame2_ram1", mem[1], 8'h02);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_data(8'd0, 8'h01);
        send_data(8'd1, 8'h02);
        send_byte(8'h03, 1'b1);
        chk_status("frame2_retry", 1'b1, 1'b0, 1'b0);

        // 256-byte frame, LEN = 0
        write_pulses = 0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) send_data(8'(i), 8'(i));
        chk("frame3_busy_csum", busy, 1'b1);
        send_byte(8'h80, 1'b1);
        chk("frame3_pulses", write_pulses, 256);
        for (int i = 0; i < 256; i++) chk("frame3_ram", {i[7:0], mem[i]}, {i[7:0], i[7:0]});
        chk_status("frame3", 1'b1, 1'b0, 1'b0);

        // Framing error on the second data byte
        write_pulses = 0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_data(8'd0, 8'h10);
        send_byte(8'h20, 1'b0);
        chk_status("frame4_ferr", 1'b0, 1'b1, 1'b1);
        chk("frame4_pulses", write_pulses, 1);
        chk("frame4_ram0", mem[0], 8'h10);
        chk("frame4_ram1_untouched", mem[1], 8'h01);

        // Stray bytes ignored, then a 1-byte frame
        write_pulses = 0;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        chk_status("stray", 1'b0, 1'b1, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_data(8'd0, 8'h7E);
        send_byte(8'h7E, 1'b1);
        chk("frame5_pulses", write_pulses, 1);
        chk("frame5_ram0", mem[0], 8'h7E);
        chk_status("frame5", 1'b1, 1'b0, 1'b0);

        // Reset mid-frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_data(8'd0, 8'h11);
        chk("frame6_busy", busy, 1'b1);
        rx = 1'b0;
        repeat (CPB + 4) tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_ram_addr", ram_addr, 8'h00);
        chk("midrst_ram_wdata", ram_wdata, 8'h00);
        chk("midrst_ram_write", ram_write, 1'b0);
        chk("midrst_ram_select", ram_select, 1'b0);
        chk_status("midrst", 1'b0, 1'b0, 1'b1);
        rx = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk_status("postrst", 1'b0, 1'b0, 1'b1);

        // Recovery after reset
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_data(8'd0, 8'h42);
        send_byte(8'h42, 1'b1);
        chk("frame7_ram0", mem[0], 8'h42);
        chk_status("frame7", 1'b1, 1'b0, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
